i2c_config_sequencer: RTL and testbench
=======================================

I2C_CONFIG_SEQUENCER -- requirements
Module: i2c_config_sequencer

Interface
REQ-001 Parameter N_REGS, default 10: number of 16-bit register words in the external table, range 1..256.
REQ-002 Parameter DEV_ADDR, default 7'h1A: 7-bit I2C slave address, R/W bit fixed 0 (write).
REQ-003 Parameter CLK_DIV, default 4: i_clk cycles per SCL quarter-period, minimum 1.
REQ-004 Parameter MAX_RETRY, default 3: extra attempts per word after a NACK, range 0..15.
REQ-005 i_clk  in  1  system clock.
REQ-006 i_rst  in  1  reset, asynchronous, active-high.
REQ-007 i_start  in  1  one-cycle pulse that starts a full table sequence.
REQ-008 o_rom_addr  out  max(1,$clog2(N_REGS))  table index currently being sent.
REQ-009 i_rom_data  in  16  table word at o_rom_addr, combinational, valid one cycle after o_rom_addr changes.
REQ-010 o_scl  out  1  SCL level; 1 = released high.
REQ-011 o_sda_oe  out  1  1 = pull SDA low, 0 = release; never drive high.
REQ-012 i_sda  in  1  sampled SDA line level.
REQ-013 o_busy  out  1  high from accepted i_start until DONE or ERR.
REQ-014 o_done  out  1  sticky, high after all N_REGS words are ACKed; cleared by the next accepted i_start.
REQ-015 o_err  out  1  sticky, high after retries are exhausted; cleared by the next accepted i_start.
REQ-016 o_err_index  out  width of o_rom_addr  index of the failing word; 0 when o_err=0.

Function
REQ-017 Quarter tick q pulses once every CLK_DIV i_clk cycles while busy; all bus changes occur only on q.
REQ-018 States: IDLE, START, BIT, ACK, STOP, GAP, DONE, ERR.
REQ-019 i_start accepted only in IDLE, DONE or ERR; ignored while busy; accepted start sets word index 0, retry count 0, clears o_done and o_err.
REQ-020 START: SCL high, SDA released for 1 q; SDA low for 2 q; then SCL low.
REQ-021 Frame: bytes {DEV_ADDR,0}, i_rom_data[15:8], i_rom_data[7:0]; each byte sent MSB first.
REQ-022 BIT, 4 q per bit: q0 SCL low, SDA set to bit (o_sda_oe = ~bit); q1 SCL low; q2–q3 SCL high.
REQ-023 ACK, 4 q after each byte: SDA released; SCL high q2–q3; i_sda sampled at end of q2; 0 = ACK, 1 = NACK.
REQ-024 ACK on bytes 0–1: next byte. ACK on byte 2: STOP, then index+1, retry count reset.
REQ-025 NACK on any byte: abort the frame through STOP. Retry count < MAX_RETRY: increment it and resend the same word. Otherwise: ERR.
REQ-026 STOP: SCL low with SDA low for 1 q; SCL high for 1 q; SDA released for 1 q.
REQ-027 GAP: bus idle (SCL=1, SDA released) for 4 q before the next START.
REQ-028 After STOP of word N_REGS-1: DONE with o_done=1, o_busy=0.
REQ-029 ERR: o_err=1, o_err_index=failing index, o_busy=0, bus released.
REQ-030 SDA changes only while SCL is low, except in START and STOP.
REQ-031 Frame bits come from a 24-bit shift register loaded in START; mid-frame changes on i_rom_data have no effect.
REQ-032 o_rom_addr wraps nowhere: after the last word it holds N_REGS-1.

Reset
REQ-033 On i_rst: state IDLE, o_scl=1, o_sda_oe=0, o_busy=0, o_done=0, o_err=0, o_err_index=0, o_rom_addr=0, counters 0.
REQ-034 Reset mid-frame releases the bus within the same cycle of assertion; no STOP is generated.
REQ-035 After reset the block stays IDLE until i_start; it does not run automatically.

Structure
REQ-036 Shared package i2c_pkg holds: state enum, BYTES_PER_FRAME=3, QUARTERS_PER_BIT=4, GAP_QUARTERS=4.
REQ-037 Sub-module i2c_tick_gen(CLK_DIV) generates q; its counter resets to 0 on i_rst and on accepted i_start.
REQ-038 All outputs are registered.

Verification
REQ-039 CLK_DIV=4, N_REGS=10, slave always ACKs, i_start pulse -> 10 frames; 1st frame bytes 0x34, table[0][15:8], table[0][7:0]; o_done=1 and o_busy=0 after the final STOP; no SDA change while SCL high outside START/STOP.
REQ-040 Slave NACKs byte 1 of word 3 twice, then ACKs -> word 3 sent 3 times, sequence completes, o_err=0.
REQ-041 MAX_RETRY=3, slave NACKs the address byte of word 5 always -> 4 attempts, o_err=1, o_err_index=5, o_done=0.
REQ-042 i_rst asserted mid-bit in word 2 -> same cycle o_scl=1, o_sda_oe=0; all outputs at reset values; a new i_start restarts at word 0.
REQ-043 i_start pulsed while busy -> ignored; a second i_start after DONE clears o_done and reruns the sequence.
REQ-044 N_REGS=1, CLK_DIV=1 -> one frame; SCL period is exactly 4 i_clk cycles; o_done=1.

Source files
------------

// File: rtl/i2c_config_sequencer_pkg.sv
// Shared types and frame constants for the I2C register-table sequencer.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BIT,
    ST_ACK,
    ST_STOP,
    ST_GAP,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam int unsigned BYTES_PER_FRAME  = 3;
  localparam int unsigned QUARTERS_PER_BIT = 4;
  localparam int unsigned GAP_QUARTERS     = 4;

endpackage

// File: rtl/i2c_config_sequencer_tick_gen.sv
// Quarter-period strobe: one i_clk-wide pulse every CLK_DIV cycles while enabled.
module i2c_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_q
);

  localparam int unsigned   CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      cnt <= '0;
    else if (i_clr)
      cnt <= '0;
    else if (i_en)
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
  end

  assign o_q = i_en && !i_clr && (cnt == LAST);

endmodule

// File: rtl/i2c_config_sequencer.sv
// Walks a table of 16-bit words and writes each one to a fixed I2C slave,
// retrying NACKed words up to MAX_RETRY times.
module i2c_config_sequencer
  import i2c_pkg::*;
#(
  parameter int unsigned N_REGS    = 10,
  parameter logic [6:0]  DEV_ADDR  = 7'h1A,
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned MAX_RETRY = 3,
  localparam int unsigned AW       = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  output logic [AW-1:0] o_rom_addr,
  input  logic [15:0]   i_rom_data,
  output logic          o_scl,
  output logic          o_sda_oe,
  input  logic          i_sda,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic [AW-1:0] o_err_index
);

  localparam logic [1:0]    QLAST = 2'(QUARTERS_PER_BIT - 1);
  localparam logic [1:0]    GLAST = 2'(GAP_QUARTERS - 1);
  localparam logic [1:0]    BLAST = 2'(BYTES_PER_FRAME - 1);
  localparam logic [AW-1:0] ALAST = AW'(N_REGS - 1);
  localparam logic [3:0]    RLIM  = 4'(MAX_RETRY);

  state_t        state, state_n;
  logic [1:0]    qcnt, q_n;
  logic [2:0]    bitcnt, bit_n;
  logic [1:0]    bytecnt, byte_n;
  logic [3:0]    retry, retry_n;
  logic [AW-1:0] idx, idx_n;
  logic [AW-1:0] err_idx, err_idx_n;
  logic [23:0]   shreg, sh_n;
  logic          nack, nack_n;
  logic          scl, scl_n, sda_oe, oe_n;
  logic          busy, busy_n, done, done_n, err, err_n;
  logic          tick, start_acc;

  assign start_acc = i_start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (start_acc),
    .i_en  (busy),
    .o_q   (tick)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      qcnt    <= '0;
      bitcnt  <= '0;
      bytecnt <= '0;
      retry   <= '0;
      idx     <= '0;
      err_idx <= '0;
      shreg   <= '0;
      nack    <= 1'b0;
      scl     <= 1'b1;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      qcnt    <= q_n;
      bitcnt  <= bit_n;
      bytecnt <= byte_n;
      retry   <= retry_n;
      idx     <= idx_n;
      err_idx <= err_idx_n;
      shreg   <= sh_n;
      nack    <= nack_n;
      scl     <= scl_n;
      sda_oe  <= oe_n;
      busy    <= busy_n;
      done    <= done_n;
      err     <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    q_n       = qcnt;
    bit_n     = bitcnt;
    byte_n    = bytecnt;
    retry_n   = retry;
    idx_n     = idx;
    err_idx_n = err_idx;
    sh_n      = shreg;
    nack_n    = nack;
    busy_n    = busy;
    done_n    = done;
    err_n     = err;
    scl_n     = 1'b1;
    oe_n      = 1'b0;

    if (start_acc) begin
      state_n   = ST_START;
      q_n       = '0;
      idx_n     = '0;
      retry_n   = '0;
      err_idx_n = '0;
      nack_n    = 1'b0;
      busy_n    = 1'b1;
      done_n    = 1'b0;
      err_n     = 1'b0;
    end else if (tick) begin
      q_n = qcnt + 2'd1;
      case (state)
        ST_START: begin
          // Table word is latched a full quarter after the address settles.
          if (qcnt == 2'd1) sh_n = {DEV_ADDR, 1'b0, i_rom_data};
          if (qcnt == QLAST) begin
            state_n = ST_BIT;
            bit_n   = '0;
            byte_n  = '0;
            nack_n  = 1'b0;
          end
        end
        ST_BIT: begin
          if (qcnt == QLAST) begin
            sh_n = {shreg[22:0], 1'b0};
            if (bitcnt == 3'd7) state_n = ST_ACK;
            else                bit_n   = bitcnt + 3'd1;
          end
        end
        ST_ACK: begin
          if (qcnt == 2'd2) nack_n = i_sda;
          if (qcnt == QLAST) begin
            if (nack || bytecnt == BLAST) begin
              state_n = ST_STOP;
            end else begin
              state_n = ST_BIT;
              byte_n  = bytecnt + 2'd1;
              bit_n   = '0;
            end
          end
        end
        ST_STOP: begin
          if (qcnt == 2'd2) begin
            q_n = '0;
            if (nack) begin
              if (retry < RLIM) begin
                retry_n = retry + 4'd1;
                state_n = ST_GAP;
              end else begin
                state_n   = ST_ERR;
                err_n     = 1'b1;
                err_idx_n = idx;
                busy_n    = 1'b0;
              end
            end else if (idx == ALAST) begin
              state_n = ST_DONE;
              done_n  = 1'b1;
              busy_n  = 1'b0;
            end else begin
              idx_n   = idx + AW'(1);
              retry_n = '0;
              state_n = ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (qcnt == GLAST) state_n = ST_START;
        end
        default: ;
      endcase
    end

    // Bus levels are decoded from the upcoming quarter so they register with it.
    case (state_n)
      ST_START: begin scl_n = (q_n != 2'd3); oe_n = (q_n != 2'd0); end
      ST_BIT:   begin scl_n = q_n[1];        oe_n = ~sh_n[23];    end
      ST_ACK:   begin scl_n = q_n[1];        oe_n = 1'b0;         end
      ST_STOP:  begin scl_n = (q_n != 2'd0); oe_n = (q_n != 2'd2); end
      default:  begin scl_n = 1'b1;          oe_n = 1'b0;         end
    endcase
  end

  assign o_rom_addr  = idx;
  assign o_scl       = scl;
  assign o_sda_oe    = sda_oe;
  assign o_busy      = busy;
  assign o_done      = done;
  assign o_err       = err;
  assign o_err_index = err_idx;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Bench for i2c_config_sequencer: I2C slave model plus byte scoreboard.
module tb_i2c_config_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, start2;
  logic [3:0]  rom_addr, err_index;
  logic [15:0] rom_q;
  logic        scl, sda_oe, busy, done, err;
  logic        slave_pull;
  logic        sda_in;
  logic [15:0] rom [10];

  logic [0:0]  rom_addr2, err_index2;
  logic        scl2, sda_oe2, busy2, done2, err2;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [7:0] exp_q [$];
  logic       exp_err;
  int         exp_err_idx;

  int         mon_word, mon_bit, mon_byte, mon_acked, mon_starts, mon_viol;
  logic [7:0] mon_sh;
  logic       mon_in_frame, mon_ack_now;
  int         nack_word, nack_byte, nack_left;

  always #5 clk = ~clk;
  always @(posedge clk) rom_q <= rom[rom_addr];
  assign sda_in = ~(sda_oe | slave_pull);

  i2c_config_sequencer dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .o_rom_addr(rom_addr), .i_rom_data(rom_q),
    .o_scl(scl), .o_sda_oe(sda_oe), .i_sda(sda_in),
    .o_busy(busy), .o_done(done), .o_err(err), .o_err_index(err_index)
  );

  i2c_config_sequencer #(.N_REGS(1), .CLK_DIV(1)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start2),
    .o_rom_addr(rom_addr2), .i_rom_data(16'hA55A),
    .o_scl(scl2), .o_sda_oe(sda_oe2), .i_sda(1'b0),
    .o_busy(busy2), .o_done(done2), .o_err(err2), .o_err_index(err_index2)
  );

  // Slave model: decodes the bus, pops expected bytes, ACKs/NACKs by policy.
  initial begin : monitor
    logic p_scl, p_sda, cs;
    logic [7:0] e;
    p_scl = 1'b1; p_sda = 1'b1; slave_pull = 1'b0;
    forever begin
      @(negedge clk);
      cs = sda_in;
      if (rst) begin
        slave_pull = 1'b0;
        cs = 1'b1;
      end else if (p_scl && scl && p_sda && !cs) begin
        if (mon_in_frame) mon_viol++;
        mon_in_frame = 1'b1; mon_bit = 0; mon_byte = 0; mon_acked = 0;
        mon_starts++;
      end else if (p_scl && scl && !p_sda && cs) begin
        if (mon_in_frame && mon_bit > 1) mon_viol++;
        if (mon_in_frame && mon_acked == 3) mon_word++;
        mon_in_frame = 1'b0;
      end else if (!p_scl && scl && mon_in_frame) begin
        if (mon_bit < 8) begin
          mon_sh = {mon_sh[6:0], cs};
          mon_bit++;
          if (mon_bit == 8) begin
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("FAIL sb_byte: got %h, nothing expected", mon_sh);
            end else begin
              e = exp_q.pop_front();
              if (mon_sh !== e) begin
                n_fail++;
                $display("FAIL sb_byte w%0d b%0d: got %h want %h", mon_word, mon_byte, mon_sh, e);
              end
            end
            mon_ack_now = !(mon_word == nack_word && mon_byte == nack_byte && nack_left > 0);
            if (!mon_ack_now) nack_left--;
          end
        end else begin
          mon_bit = 0;
          if (mon_ack_now) mon_acked++;
          mon_byte++;
        end
      end else if (p_scl && !scl) begin
        slave_pull = (mon_bit == 8) && mon_ack_now;
      end
      p_scl = rst ? 1'b1 : scl;
      p_sda = cs;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin to = 1'b0; break; end
    end
  endtask

  task automatic launch(input int nw, input int nb, input int nt);
    exp_q.delete();
    exp_err = 1'b0; exp_err_idx = 0;
    for (int i = 0; i < 10; i++) rom[i] = 16'($urandom);
    nack_word = nw; nack_byte = nb; nack_left = nt;
    mon_word = 0; mon_bit = 0; mon_byte = 0; mon_acked = 0;
    mon_starts = 0; mon_viol = 0; mon_in_frame = 1'b0; mon_ack_now = 1'b1;
    begin : build
      for (int w = 0; w < 10; w++) begin
        int a;
        logic [7:0] fb [3];
        fb[0] = 8'h34; fb[1] = rom[w][15:8]; fb[2] = rom[w][7:0];
        a = 0;
        while (w == nw && a < nt) begin
          for (int b = 0; b <= nb; b++) exp_q.push_back(fb[b]);
          if (a == 3) begin exp_err = 1'b1; exp_err_idx = w; disable build; end
          a++;
        end
        for (int b = 0; b < 3; b++) exp_q.push_back(fb[b]);
      end
    end
    pulse_start();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if ({scl, sda_oe, busy, done, err} !== 5'b10000) begin n_fail++; $display("FAIL reset_ctrl: got %b want 10000", {scl, sda_oe, busy, done, err}); end
    n_checks++; if ({rom_addr, err_index} !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h want 00", {rom_addr, err_index}); end
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    n_checks++; if ({scl, sda_oe, busy, rom_addr} !== 7'b1000000) begin n_fail++; $display("FAIL reset_stays_idle: got %b want 1000000", {scl, sda_oe, busy, rom_addr}); end
  endtask

  task automatic test_full_sequence();
    bit to;
    launch(-1, 0, 0);
    wait_idle(20000, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL full_timeout: got %b want 0", to); end
    n_checks++; if ({done, busy, err} !== 3'b100) begin n_fail++; $display("FAIL full_status: got %b want 100", {done, busy, err}); end
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL full_leftover: got %0d want 0", exp_q.size()); end
    n_checks++; if (mon_starts !== 10) begin n_fail++; $display("FAIL full_frames: got %0d want 10", mon_starts); end
    n_checks++; if (mon_viol !== 0) begin n_fail++; $display("FAIL full_sda_while_scl_high: got %0d want 0", mon_viol); end
    n_checks++; if (rom_addr !== 4'd9) begin n_fail++; $display("FAIL full_addr_hold: got %0d want 9", rom_addr); end
    n_checks++; if ({scl, sda_oe} !== 2'b10) begin n_fail++; $display("FAIL full_bus_released: got %b want 10", {scl, sda_oe}); end
  endtask

  task automatic test_back_to_back();
    bit to;
    launch(-1, 0, 0);
    repeat (700) @(posedge clk);
    pulse_start();
    wait_idle(20000, to);
    n_checks++; if ({to, done, busy} !== 3'b010) begin n_fail++; $display("FAIL b2b_first: got %b want 010", {to, done, busy}); end
    n_checks++; if (mon_starts !== 10 || exp_q.size() !== 0) begin n_fail++; $display("FAIL b2b_ignored_start: got frames %0d left %0d want 10 0", mon_starts, exp_q.size()); end
    launch(-1, 0, 0);
    n_checks++; if ({done, busy} !== 2'b01) begin n_fail++; $display("FAIL b2b_restart_clears_done: got %b want 01", {done, busy}); end
    wait_idle(20000, to);
    n_checks++; if ({to, done, exp_q.size() == 0} !== 3'b011) begin n_fail++; $display("FAIL b2b_rerun: got %b want 011", {to, done, exp_q.size() == 0}); end
  endtask

  task automatic test_retry();
    bit to;
    launch(3, 1, 2);
    wait_idle(30000, to);
    n_checks++; if ({to, done, err} !== 3'b010) begin n_fail++; $display("FAIL retry_status: got %b want 010", {to, done, err}); end
    n_checks++; if (mon_starts !== 12 || mon_word !== 10) begin n_fail++; $display("FAIL retry_frames: got %0d/%0d want 12/10", mon_starts, mon_word); end
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL retry_leftover: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_error();
    bit to;
    launch(5, 0, 100);
    wait_idle(30000, to);
    n_checks++; if ({to, err, done, busy} !== {1'b0, exp_err, 2'b00}) begin n_fail++; $display("FAIL err_status: got %b want 0100", {to, err, done, busy}); end
    n_checks++; if (err_index !== 4'(exp_err_idx)) begin n_fail++; $display("FAIL err_index: got %0d want %0d", err_index, exp_err_idx); end
    n_checks++; if (mon_starts !== 9 || exp_q.size() !== 0) begin n_fail++; $display("FAIL err_attempts: got frames %0d left %0d want 9 0", mon_starts, exp_q.size()); end
    n_checks++; if ({scl, sda_oe} !== 2'b10) begin n_fail++; $display("FAIL err_bus_released: got %b want 10", {scl, sda_oe}); end
  endtask

  task automatic test_reset_midframe();
    bit to, hit;
    launch(-1, 0, 0);
    n_checks++; if ({err, busy} !== 2'b01) begin n_fail++; $display("FAIL restart_clears_err: got %b want 01", {err, busy}); end
    hit = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (mon_word == 2 && mon_bit >= 3 && !scl && sda_oe) begin hit = 1'b1; break; end
    end
    n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL midframe_reach: got %b want 1", hit); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({scl, sda_oe} !== 2'b10) begin n_fail++; $display("FAIL midframe_bus_release: got %b want 10", {scl, sda_oe}); end
    n_checks++; if ({busy, done, err, rom_addr, err_index} !== 11'd0) begin n_fail++; $display("FAIL midframe_outputs: got %b want 0", {busy, done, err, rom_addr, err_index}); end
    @(posedge clk); #1 rst = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    n_checks++; if ({busy, scl} !== 2'b01) begin n_fail++; $display("FAIL midframe_no_autorun: got %b want 01", {busy, scl}); end
    launch(-1, 0, 0);
    wait_idle(20000, to);
    n_checks++; if ({to, done, mon_starts == 10, exp_q.size() == 0} !== 4'b0111) begin n_fail++; $display("FAIL midframe_rerun: got %b want 0111", {to, done, mon_starts == 10, exp_q.size() == 0}); end
  endtask

  task automatic test_small_config();
    int   rise_t [32];
    logic bits   [32];
    int   nrise, bad, cyc;
    logic p2;
    logic [7:0] b0, b1, b2;
    nrise = 0; bad = 0; cyc = 0; p2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      cyc++;
      if (!p2 && scl2 && nrise < 32) begin
        rise_t[nrise] = cyc; bits[nrise] = ~sda_oe2; nrise++;
      end
      p2 = scl2;
      if (!busy2) break;
    end
    n_checks++; if (nrise !== 28) begin n_fail++; $display("FAIL small_scl_rises: got %0d want 28", nrise); end
    for (int i = 1; i < 27 && i < nrise; i++) if (rise_t[i] - rise_t[i-1] != 4) bad++;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL small_scl_period: got %0d bad periods want 0", bad); end
    for (int i = 0; i < 8; i++) begin b0[7-i] = bits[i]; b1[7-i] = bits[9+i]; b2[7-i] = bits[18+i]; end
    n_checks++; if ({b0, b1, b2} !== 24'h34A55A) begin n_fail++; $display("FAIL small_frame: got %h want 34A55A", {b0, b1, b2}); end
    n_checks++; if ({done2, busy2, err2, rom_addr2} !== 4'b1000) begin n_fail++; $display("FAIL small_status: got %b want 1000", {done2, busy2, err2, rom_addr2}); end
  endtask

  initial begin
    nack_word = -1; nack_byte = 0; nack_left = 0;
    mon_in_frame = 1'b0; mon_ack_now = 1'b1; mon_bit = 0;
    for (int i = 0; i < 10; i++) rom[i] = '0;
    test_reset();
    test_full_sequence();
    test_back_to_back();
    test_retry();
    test_error();
    test_reset_midframe();
    test_small_config();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
